// File: rtl/stage_ex.sv
// stage_ex -- execute stage of the pipeline.
// Logic, shift and arithmetic operations resolve combinationally in the
// same cycle. Divide runs on a multi-cycle restoring divider that stalls
// the front of the pipe while it works.
// Optional feature macro: DIVIDER_EN. Without it, divide requests behave
// as nops and no divider hardware is built.
module stage_ex (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  ex_operator,
    input  logic [2:0]  ex_category,
    input  logic [31:0] ex_operand_a,
    input  logic [31:0] ex_operand_b,
    input  logic        ex_register_write_enable,
    input  logic [4:0]  ex_register_write_address,
    input  logic        flush,
    output logic        mem_register_write_enable,
    output logic [4:0]  mem_register_write_address,
    output logic [31:0] mem_register_write_data,
    output logic        mem_hilo_write_enable,
    output logic [31:0] mem_hi,
    output logic [31:0] mem_lo,
    output logic        stall_request
);

    logic        aluValid;
    logic [31:0] aluData;
    logic        inAluClass;
    logic        divStall;
    logic        divHiloWe;
    logic [31:0] divHi;
    logic [31:0] divLo;

    assign inAluClass = (ex_category == 3'd1) || (ex_category == 3'd2) ||
                        (ex_category == 3'd3);

    // Single-cycle ALU; aluValid marks a recognised operator so unknown
    // codes yield zero data and never write the register file.
    always_comb begin
        aluValid = 1'b0;
        aluData  = 32'd0;
        case (ex_category)
            3'd1: begin
                case (ex_operator)
                    8'h01: begin aluValid = 1'b1; aluData = ex_operand_a & ex_operand_b; end
                    8'h02: begin aluValid = 1'b1; aluData = ex_operand_a | ex_operand_b; end
                    8'h03: begin aluValid = 1'b1; aluData = ex_operand_a ^ ex_operand_b; end
                    8'h04: begin aluValid = 1'b1; aluData = ~(ex_operand_a | ex_operand_b); end
                    default: ;
                endcase
            end
            3'd2: begin
                case (ex_operator)
                    8'h10: begin aluValid = 1'b1; aluData = ex_operand_b << ex_operand_a[4:0]; end
                    8'h11: begin aluValid = 1'b1; aluData = ex_operand_b >> ex_operand_a[4:0]; end
                    8'h12: begin
                        aluValid = 1'b1;
                        aluData  = $signed(ex_operand_b) >>> ex_operand_a[4:0];
                    end
                    default: ;
                endcase
            end
            3'd3: begin
                case (ex_operator)
                    8'h20: begin aluValid = 1'b1; aluData = ex_operand_a + ex_operand_b; end
                    8'h21: begin aluValid = 1'b1; aluData = ex_operand_a - ex_operand_b; end
                    8'h22: begin
                        aluValid = 1'b1;
                        aluData  = {31'd0, ($signed(ex_operand_a) < $signed(ex_operand_b))};
                    end
                    8'h23: begin
                        aluValid = 1'b1;
                        aluData  = {31'd0, (ex_operand_a < ex_operand_b)};
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

`ifdef DIVIDER_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} divState_t;

    divState_t   divState_q;
    logic [5:0]  divCount_q;
    logic [31:0] quotient_q;
    logic [31:0] remainder_q;
    logic [31:0] divisor_q;
    logic        quoNeg_q;
    logic        remNeg_q;

    logic        divStart;
    logic        divSigned;
    logic        aNeg;
    logic        bNeg;
    logic [31:0] aMag;
    logic [31:0] bMag;
    logic [32:0] remShift;
    logic [33:0] trialDiff;
    logic [31:0] quotient_d;
    logic [31:0] remainder_d;

    assign divStart  = (ex_category == 3'd4) &&
                       ((ex_operator == 8'h30) || (ex_operator == 8'h31));
    assign divSigned = (ex_operator == 8'h30);
    assign aNeg      = divSigned & ex_operand_a[31];
    assign bNeg      = divSigned & ex_operand_b[31];
    assign aMag      = aNeg ? (~ex_operand_a + 32'd1) : ex_operand_a;
    assign bMag      = bNeg ? (~ex_operand_b + 32'd1) : ex_operand_b;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and keep the subtraction only if it did not borrow.
    assign remShift    = {remainder_q, quotient_q[31]};
    assign trialDiff   = {1'b0, remShift} - {2'b00, divisor_q};
    assign remainder_d = trialDiff[33] ? remShift[31:0] : trialDiff[31:0];
    assign quotient_d  = {quotient_q[30:0], ~trialDiff[33]};

    // Divider FSM: the quotient register starts as the dividend magnitude
    // and is shifted out while quotient bits shift in; signs are applied
    // on the final step so DONE presents the finished result.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            divState_q  <= IDLE;
            divCount_q  <= 6'd0;
            quotient_q  <= 32'd0;
            remainder_q <= 32'd0;
            divisor_q   <= 32'd0;
            quoNeg_q    <= 1'b0;
            remNeg_q    <= 1'b0;
        end else if (flush) begin
            divState_q <= IDLE;
            divCount_q <= 6'd0;
        end else begin
            case (divState_q)
                IDLE: begin
                    if (divStart) begin
                        quoNeg_q   <= aNeg ^ bNeg;
                        remNeg_q   <= aNeg;
                        divCount_q <= 6'd0;
                        if (ex_operand_b == 32'd0) begin
                            quotient_q  <= 32'hFFFF_FFFF;
                            remainder_q <= ex_operand_a;
                            divState_q  <= DONE;
                        end else begin
                            quotient_q  <= aMag;
                            remainder_q <= 32'd0;
                            divisor_q   <= bMag;
                            divState_q  <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    divCount_q <= divCount_q + 6'd1;
                    if (divCount_q == 6'd31) begin
                        quotient_q  <= quoNeg_q ? (~quotient_d + 32'd1) : quotient_d;
                        remainder_q <= remNeg_q ? (~remainder_d + 32'd1) : remainder_d;
                        divState_q  <= DONE;
                    end else begin
                        quotient_q  <= quotient_d;
                        remainder_q <= remainder_d;
                    end
                end
                DONE: begin
                    divState_q <= IDLE;
                    divCount_q <= 6'd0;
                end
                default: divState_q <= IDLE;
            endcase
        end
    end

    assign divStall  = reset & ~flush &
                       (((divState_q == IDLE) & divStart) | (divState_q == BUSY));
    assign divHiloWe = reset & ~flush & (divState_q == DONE);
    assign divHi     = (reset && divState_q == DONE) ? remainder_q : 32'd0;
    assign divLo     = (reset && divState_q == DONE) ? quotient_q  : 32'd0;
`else
    logic unusedClock;

    assign unusedClock = clock;
    assign divStall    = 1'b0;
    assign divHiloWe   = 1'b0;
    assign divHi       = 32'd0;
    assign divLo       = 32'd0;
`endif

    assign mem_register_write_enable  = reset & ~flush & ex_register_write_enable & aluValid;
    assign mem_register_write_address = (reset && inAluClass) ? ex_register_write_address : 5'd0;
    assign mem_register_write_data    = reset ? aluData : 32'd0;
    assign mem_hilo_write_enable      = divHiloWe;
    assign mem_hi                     = divHi;
    assign mem_lo                     = divLo;
    assign stall_request              = divStall;

endmodule
